alu_operand_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_operand_sequencer_debounce_sync.sv | 45 ++++
 rtl/alu_operand_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_operand_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 2-bit ALU front end: op-select codes and sequencer FSM states.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam int NUM_RAW_INPUTS = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } seq_state_e;

endpackage

// File: rtl/alu_operand_sequencer_debounce_sync.sv
// One-bit two-flop synchronizer followed by a counting debouncer (latency 2 + DEBOUNCE_CYCLES).
module debounce_sync #(
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic dout
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synced level matches the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Debounces board inputs, captures a/b/sel on a LOAD press and offers them with valid/ready.
// Optional macro ALU_SEQ_DROP_CNT_EN adds DROP_CNT, a saturating count of presses lost while busy.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BUTTONS,
  input  logic [1:0] SWITCHES,
  input  logic       LOAD,
  input  logic       OP_READY,
  output logic [1:0] A_OUT,
  output logic [1:0] B_OUT,
  output logic [1:0] SEL_OUT,
  output logic       OP_VALID,
`ifdef ALU_SEQ_DROP_CNT_EN
  output logic [3:0] DROP_CNT,
`endif
  output logic       BUSY
);

  logic [NUM_RAW_INPUTS-1:0] raw_vec;
  logic [NUM_RAW_INPUTS-1:0] deb_vec;
  logic                      load_prev_q;
  logic                      load_rise;

  seq_state_e state_q, state_d;
  logic [1:0] a_q, a_d, b_q, b_d, sel_q, sel_d;
  logic       valid_q, valid_d, busy_q, busy_d;

  assign raw_vec = {LOAD, SWITCHES, BUTTONS};

  for (genvar i = 0; i < NUM_RAW_INPUTS; i++) begin : g_deb
    debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .CLK  (CLK),
      .RST_N(RST_N),
      .din  (raw_vec[i]),
      .dout (deb_vec[i])
    );
  end

  assign load_rise = deb_vec[6] & ~load_prev_q;

  // A press seen while VALID is simply lost; nothing is queued for later.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (load_rise) begin
          a_d     = deb_vec[1:0];
          b_d     = deb_vec[3:2];
          sel_d   = deb_vec[5:4];
          state_d = ST_VALID;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_VALID: begin
        if (OP_READY) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      a_q         <= 2'b00;
      b_q         <= 2'b00;
      sel_q       <= 2'b00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      load_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      load_prev_q <= deb_vec[6];
    end
  end

  assign A_OUT    = a_q;
  assign B_OUT    = b_q;
  assign SEL_OUT  = sel_q;
  assign OP_VALID = valid_q;
  assign BUSY     = busy_q;

`ifdef ALU_SEQ_DROP_CNT_EN
  logic [3:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (load_rise) begin
      if (state_q == ST_VALID) begin
        if (drop_q != 4'hF) drop_d = drop_q + 4'd1;
      end else begin
        drop_d = 4'd0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) drop_q <= 4'd0;
    else        drop_q <= drop_d;
  end

  assign DROP_CNT = drop_q;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer (DEBOUNCE_CYCLES=4); scoreboarded transfers plus directed corner cases.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] BUTTONS;
  logic [1:0] SWITCHES;
  logic       LOAD;
  logic       OP_READY;
  logic [1:0] A_OUT, B_OUT, SEL_OUT;
  logic       OP_VALID, BUSY;
`ifdef ALU_SEQ_DROP_CNT_EN
  logic [3:0] DROP_CNT;
`endif

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .BUTTONS (BUTTONS),
    .SWITCHES(SWITCHES),
    .LOAD    (LOAD),
    .OP_READY(OP_READY),
    .A_OUT   (A_OUT),
    .B_OUT   (B_OUT),
    .SEL_OUT (SEL_OUT),
    .OP_VALID(OP_VALID),
`ifdef ALU_SEQ_DROP_CNT_EN
    .DROP_CNT(DROP_CNT),
`endif
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] buttons;
    logic [1:0] switches;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    logic [1:0] exp_sel;
  } vec_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Inputs change 2 time units after each rising edge, so they are stable at the negedge and next posedge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] btn, input logic [1:0] sw);
    BUTTONS  = btn;
    SWITCHES = sw;
    tick(8);
  endtask

  task automatic pushExpected(input logic [1:0] a, input logic [1:0] b, input logic [1:0] sel);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.sel = sel;
    exp_q.push_back(e);
  endtask

  // A transfer happens on the next posedge whenever OP_VALID && OP_READY at the negedge.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (RST_N && OP_VALID && OP_READY) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_transfer: got a=%0d b=%0d sel=%0d, expected no transfer",
                 A_OUT, B_OUT, SEL_OUT);
      end else begin
        e = exp_q.pop_front();
        checkOutput("xfer_a", int'(A_OUT), int'(e.a));
        checkOutput("xfer_b", int'(B_OUT), int'(e.b));
        checkOutput("xfer_sel", int'(SEL_OUT), int'(e.sel));
      end
    end
  end

  initial begin
    vec_t vecs[4];
    int   lat;
    int   cnt;

    vecs[0] = '{4'b0000, 2'b01, 2'b00, 2'b00, OP_OR};
    vecs[1] = '{4'b0110, 2'b00, 2'b10, 2'b01, OP_AND};
    vecs[2] = '{4'b1001, 2'b11, 2'b01, 2'b10, OP_SUB};
    vecs[3] = '{4'b1111, 2'b10, 2'b11, 2'b11, OP_ADD};

    RST_N    = 1'b0;
    BUTTONS  = 4'b0000;
    SWITCHES = 2'b00;
    LOAD     = 1'b0;
    OP_READY = 1'b0;
    tick(3);
    RST_N = 1'b1;
    tick(1);

    checkOutput("reset_a", int'(A_OUT), 0);
    checkOutput("reset_b", int'(B_OUT), 0);
    checkOutput("reset_sel", int'(SEL_OUT), 0);
    checkOutput("reset_valid", int'(OP_VALID), 0);
    checkOutput("reset_busy", int'(BUSY), 0);

    // Bounce rejection: pulses shorter than the debounce window never register.
    for (int k = 0; k < 4; k++) begin
      LOAD = (k % 2 == 0);
      tick(2);
    end
    LOAD = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (OP_VALID) cnt++;
    end
    checkOutput("bounce_valid_cycles", cnt, 0);
    checkOutput("bounce_a", int'(A_OUT), 0);
    checkOutput("bounce_sel", int'(SEL_OUT), 0);

    // Clean press held with OP_READY low.
    applyStimulus(4'b1011, 2'b10);
    pushExpected(2'b11, 2'b10, OP_ADD);
    exp_q.delete();
    pushExpected(2'b11, 2'b10, OP_ADD);
    LOAD = 1'b1;
    lat  = 99;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (OP_VALID) begin
        lat = i;
        break;
      end
    end
    checkOutput("clean_latency", lat, 7);
    checkOutput("clean_a", int'(A_OUT), 2'b11);
    checkOutput("clean_b", int'(B_OUT), 2'b10);
    checkOutput("clean_sel", int'(SEL_OUT), int'(OP_ADD));
    checkOutput("clean_busy", int'(BUSY), 1);

    // While VALID: operands change and a second press arrives; both must be ignored.
    BUTTONS  = 4'b0000;
    SWITCHES = 2'b01;
    LOAD     = 1'b0;
    cnt      = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!OP_VALID) cnt++;
    end
    LOAD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!OP_VALID) cnt++;
    end
    checkOutput("hold_valid_low_cycles", cnt, 0);
    checkOutput("frozen_a", int'(A_OUT), 2'b11);
    checkOutput("frozen_b", int'(B_OUT), 2'b10);
    checkOutput("frozen_sel", int'(SEL_OUT), int'(OP_ADD));

    OP_READY = 1'b1;
    tick(1);
    OP_READY = 1'b0;
    checkOutput("accept_valid", int'(OP_VALID), 0);
    checkOutput("accept_busy", int'(BUSY), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (OP_VALID) cnt++;
    end
    checkOutput("dropped_press_valid_cycles", cnt, 0);
    checkOutput("idle_keeps_a", int'(A_OUT), 2'b11);
`ifdef ALU_SEQ_DROP_CNT_EN
    checkOutput("drop_cnt_after_drop", int'(DROP_CNT), 1);
`endif
    LOAD = 1'b0;
    tick(10);

    // OP_READY tied high: each press yields exactly one single-cycle pulse.
    OP_READY = 1'b1;
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].buttons, vecs[v].switches);
      pushExpected(vecs[v].exp_a, vecs[v].exp_b, vecs[v].exp_sel);
      LOAD = 1'b1;
      cnt  = 0;
      for (int i = 0; i < 15; i++) begin
        tick(1);
        if (OP_VALID) cnt++;
      end
      checkOutput("pulse_cycles", cnt, 1);
      checkOutput("pulse_idle_a", int'(A_OUT), int'(vecs[v].exp_a));
      LOAD = 1'b0;
      tick(8);
    end
`ifdef ALU_SEQ_DROP_CNT_EN
    checkOutput("drop_cnt_cleared", int'(DROP_CNT), 0);
`endif

    // Asynchronous reset while VALID drops the pending set.
    OP_READY = 1'b0;
    applyStimulus(4'b0110, 2'b11);
    pushExpected(2'b10, 2'b01, OP_SUB);
    LOAD = 1'b1;
    lat  = 99;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (OP_VALID) begin
        lat = i;
        break;
      end
    end
    checkOutput("pre_reset_latency", lat, 7);
    RST_N = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("async_reset_valid", int'(OP_VALID), 0);
    checkOutput("async_reset_busy", int'(BUSY), 0);
    checkOutput("async_reset_a", int'(A_OUT), 0);
    checkOutput("async_reset_b", int'(B_OUT), 0);
    checkOutput("async_reset_sel", int'(SEL_OUT), 0);
    #4;
    RST_N = 1'b1;
    pushExpected(2'b10, 2'b01, OP_SUB);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (OP_VALID) begin
        lat = i;
        break;
      end
    end
    checkOutput("post_reset_recapture_latency", lat, 7);
    checkOutput("post_reset_a", int'(A_OUT), 2'b10);
    checkOutput("post_reset_sel", int'(SEL_OUT), int'(OP_SUB));
    OP_READY = 1'b1;
    tick(2);
    checkOutput("post_reset_accept_valid", int'(OP_VALID), 0);
    LOAD = 1'b0;
    tick(10);

    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
